branch_sequencer: RTL and testbench



---
 rtl/branch_sequencer.sv | 121 ++++++++++++
 tb/tb_branch_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: owns NZCV, evaluates condition codes, drives PC redirect then a timed flush.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters and their ports.
module branch_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flag_we,
    input  logic [3:0]            flags_in,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [5:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    input  logic                  fetch_ready,
    output logic                  flush,
    output logic                  resolved,
    output logic                  taken,
`ifdef BRANCH_STATS_EN
    output logic [15:0]           stat_taken,
    output logic [15:0]           stat_not_taken,
`endif
    output logic [3:0]            flags
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [1:0]            state;
    logic [3:0]            flags_q;
    logic [3:0]            eff;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] target_q;
    logic                  nt_pulse;
    logic                  cond_pass;
    logic                  last_flush;

    // Same-cycle forwarding from the ALU write port.
    assign eff = flag_we ? flags_in : flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (br_cond)
            6'd0:    cond_pass = eff[2];
            6'd1:    cond_pass = !eff[2];
            6'd2:    cond_pass = eff[1];
            6'd3:    cond_pass = !eff[1];
            6'd4:    cond_pass = eff[3];
            6'd5:    cond_pass = !eff[3];
            6'd6:    cond_pass = eff[0];
            6'd7:    cond_pass = !eff[0];
            6'd8:    cond_pass = eff[1] && !eff[2];
            6'd9:    cond_pass = !eff[1] || eff[2];
            6'd10:   cond_pass = eff[3] == eff[0];
            6'd11:   cond_pass = eff[3] != eff[0];
            6'd12:   cond_pass = !eff[2] && (eff[3] == eff[0]);
            6'd13:   cond_pass = eff[2] || (eff[3] != eff[0]);
            6'd14,
            6'd15:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            flags_q  <= 4'b0000;
            target_q <= '0;
            cnt      <= 4'd0;
            nt_pulse <= 1'b0;
        end else begin
            if (flag_we) flags_q <= flags_in;
            nt_pulse <= 1'b0;
            case (state)
                IDLE: if (br_valid) begin
                    target_q <= br_target;
                    if (cond_pass) state <= REDIRECT;
                    else           nt_pulse <= 1'b1;
                end
                REDIRECT: if (fetch_ready) begin
                    state <= FLUSH;
                    cnt   <= FLUSH_LAST;
                end
                FLUSH: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers; resolved coincides with the final flush cycle.
    assign last_flush = (state == FLUSH) && (cnt == 4'd0);
    assign br_ready   = (state == IDLE);
    assign pc_load    = (state == REDIRECT);
    assign flush      = (state == FLUSH);
    assign resolved   = nt_pulse || last_flush;
    assign taken      = last_flush;
    assign pc_target  = target_q;
    assign flags      = flags_q;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_taken     <= 16'd0;
            stat_not_taken <= 16'd0;
        end else if (resolved) begin
            if (taken && stat_taken != 16'hFFFF)
                stat_taken <= stat_taken + 16'd1;
            if (!taken && stat_not_taken != 16'hFFFF)
                stat_not_taken <= stat_not_taken + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed timing checks plus a full condition/flag sweep.
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flag_we = 1'b0;
    logic [3:0]  flags_in = 4'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [5:0]  br_cond = 6'd0;
    logic [31:0] br_target = 32'd0;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        fetch_ready = 1'b1;
    logic        flush;
    logic        resolved;
    logic        taken;
    logic [3:0]  flags;

    typedef struct {
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    branch_sequencer #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .flag_we(flag_we), .flags_in(flags_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
        .pc_load(pc_load), .pc_target(pc_target), .fetch_ready(fetch_ready),
        .flush(flush), .resolved(resolved), .taken(taken), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pairs of conditions share a base predicate; odd codes invert it.
    function automatic logic model(input logic [5:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        {n, z, cf, v} = f;
        if (c >= 6'd16) return 1'b0;
        if (c[3:1] == 3'b111) return 1'b1;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b0;
        endcase
        return b ^ c[0];
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            if (resolved) begin
                if (sb.size() == 0) chk("spurious_resolved", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("taken", {31'd0, taken}, {31'd0, e.tk});
                end
            end
            if (pc_load && sb.size() > 0) chk("pc_target", pc_target, sb[0].tgt);
        end
    end

    task automatic wait_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we  = 1'b1;
        flags_in = f;
        wait_clk();
        flag_we  = 1'b0;
    endtask

    task automatic issue(input logic [5:0] c, input logic [31:0] t, input logic e);
        exp_t x;
        x.tk = e;
        x.tgt = t;
        br_valid  = 1'b1;
        br_cond   = c;
        br_target = t;
        sb.push_back(x);
        wait_clk();
        br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || !br_ready) && k < 100) begin
            wait_clk();
            k++;
        end
        if (k >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_flags"},     {28'd0, flags},     32'd0);
        chk({pfx, "_br_ready"},  {31'd0, br_ready},  32'd1);
        chk({pfx, "_pc_load"},   {31'd0, pc_load},   32'd0);
        chk({pfx, "_flush"},     {31'd0, flush},     32'd0);
        chk({pfx, "_resolved"},  {31'd0, resolved},  32'd0);
        chk({pfx, "_taken"},     {31'd0, taken},     32'd0);
        chk({pfx, "_pc_target"}, pc_target,          32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (2) wait_clk();
        chk_reset_vals("rst");
        reset = 1'b0;
        wait_clk();

        // Taken EQ with full cycle-by-cycle timing
        set_flags(4'b0100);
        chk("flags_wr", {28'd0, flags}, 32'h4);
        issue(6'd0, 32'h100, 1'b1);
        chk("t1_pc_load", {31'd0, pc_load}, 32'd1);
        chk("t1_br_ready", {31'd0, br_ready}, 32'd0);
        chk("t1_pc_target", pc_target, 32'h100);
        wait_clk();
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_pc_load", {31'd0, pc_load}, 32'd0);
        chk("t2_resolved", {31'd0, resolved}, 32'd0);
        wait_clk();
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_resolved", {31'd0, resolved}, 32'd1);
        chk("t3_taken", {31'd0, taken}, 32'd1);
        wait_clk();
        chk("t4_flush", {31'd0, flush}, 32'd0);
        chk("t4_br_ready", {31'd0, br_ready}, 32'd1);
        chk("t4_resolved", {31'd0, resolved}, 32'd0);

        // Not taken: one-cycle resolution, no redirect
        set_flags(4'b0000);
        issue(6'd0, 32'h200, 1'b0);
        chk("nt_resolved", {31'd0, resolved}, 32'd1);
        chk("nt_taken", {31'd0, taken}, 32'd0);
        chk("nt_pc_load", {31'd0, pc_load}, 32'd0);
        chk("nt_br_ready", {31'd0, br_ready}, 32'd1);
        wait_clk();
        chk("nt_resolved_drop", {31'd0, resolved}, 32'd0);
        wait_idle();

        // Bypass: Z arrives from the ALU in the evaluating cycle
        begin
            exp_t x;
            x.tk = 1'b1;
            x.tgt = 32'h300;
            flag_we = 1'b1; flags_in = 4'b0100;
            br_valid = 1'b1; br_cond = 6'd0; br_target = 32'h300;
            sb.push_back(x);
            wait_clk();
            flag_we = 1'b0; br_valid = 1'b0;
            chk("byp_pc_load", {31'd0, pc_load}, 32'd1);
            chk("byp_flags", {28'd0, flags}, 32'h4);
            wait_idle();
        end

        // Full sweep of every condition code against every flag pattern
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 64; c++) begin
                issue(6'(c), {20'h0, 4'(f), 2'b0, 6'(c)}, model(6'(c), 4'(f)));
                wait_idle();
            end
        end

        // Fetch back-pressure during redirect
        set_flags(4'b0000);
        fetch_ready = 1'b0;
        issue(6'd14, 32'hABC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_pc_load", {31'd0, pc_load}, 32'd1);
            chk("bp_pc_target", pc_target, 32'hABC);
            chk("bp_br_ready", {31'd0, br_ready}, 32'd0);
            chk("bp_flush", {31'd0, flush}, 32'd0);
            wait_clk();
        end
        fetch_ready = 1'b1;
        wait_clk();
        chk("bp_flush_rise", {31'd0, flush}, 32'd1);
        wait_idle();

        // Reset in the middle of a flush
        set_flags(4'b1011);
        issue(6'd15, 32'hDEF, 1'b1);
        wait_clk();
        chk("ab_flush", {31'd0, flush}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("ab");
        sb.delete();
        wait_clk();
        wait_clk();
        reset = 1'b0;
        issue(6'd1, 32'h44, 1'b1);
        chk("post_rst_pc_load", {31'd0, pc_load}, 32'd1);
        wait_idle();
        issue(6'd0, 32'h48, 1'b0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
